// File: rtl/cordic_job_sequencer.sv
// Feeds one operand set per handshake into the iterative CORDIC core and captures its x/y/z after N+1 edges.
// Backpressure: in_ready only in IDLE; a finished job parks in HOLD until the single-entry result register frees.
`timescale 1ns/1ps
module cordic_job_sequencer #(
    parameter int WHOLE_BIT_WIDTH   = 3,
    parameter int DECIMAL_BIT_WIDTH = 5,
    parameter int BIT_WIDTH         = WHOLE_BIT_WIDTH + DECIMAL_BIT_WIDTH,
    parameter int CYCLES_CIRC       = 12,
    parameter int CYCLES_LIN        = 10,
    parameter int CYCLES_HYP        = 14
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [BIT_WIDTH-1:0] i_in_x,
    input  logic [BIT_WIDTH-1:0] i_in_y,
    input  logic [BIT_WIDTH-1:0] i_in_z,
    input  logic                 i_in_mode,
    input  logic [1:0]           i_in_coord,
    output logic [BIT_WIDTH-1:0] o_core_x_initial,
    output logic [BIT_WIDTH-1:0] o_core_y_initial,
    output logic [BIT_WIDTH-1:0] o_core_z_initial,
    output logic                 o_core_mode_bit,
    output logic [1:0]           o_core_coordinate_system,
    output logic                 o_core_restart,
    input  logic [BIT_WIDTH-1:0] i_core_x,
    input  logic [BIT_WIDTH-1:0] i_core_y,
    input  logic [BIT_WIDTH-1:0] i_core_z,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [BIT_WIDTH-1:0] o_out_x,
    output logic [BIT_WIDTH-1:0] o_out_y,
    output logic [BIT_WIDTH-1:0] o_out_z,
    output logic [1:0]           o_out_coord,
    output logic                 o_out_err
);

    localparam int MAX_CYC = (CYCLES_CIRC > CYCLES_LIN)
                           ? ((CYCLES_CIRC > CYCLES_HYP) ? CYCLES_CIRC : CYCLES_HYP)
                           : ((CYCLES_LIN  > CYCLES_HYP) ? CYCLES_LIN  : CYCLES_HYP);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_load;
    logic [BIT_WIDTH-1:0] r_core_x, r_core_y, r_core_z;
    logic                 r_core_mode;
    logic [1:0]           r_core_coord;
    logic                 r_out_valid;
    logic [BIT_WIDTH-1:0] r_out_x, r_out_y, r_out_z;
    logic [1:0]           r_out_coord;
    logic                 r_out_err;
    logic                 w_hs;
    logic                 w_rsv;
    logic                 w_out_free;
    logic                 w_cap;

    assign w_rsv      = (i_in_coord == 2'b11);
    assign w_out_free = !r_out_valid || i_out_ready;
    // A reserved-coord job writes the result register at accept, so it also needs that register free.
    assign o_in_ready = (r_state == IDLE) && !(w_rsv && !w_out_free);
    assign w_hs       = i_in_valid && o_in_ready;
    assign w_cap      = ((r_state == RUN && r_cnt == '0) || r_state == HOLD) && w_out_free;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = CNT_W'(CYCLES_CIRC - 1);
        case (r_core_coord)
            2'b01:   w_cnt_load = CNT_W'(CYCLES_LIN - 1);
            2'b10:   w_cnt_load = CNT_W'(CYCLES_HYP - 1);
            default: w_cnt_load = CNT_W'(CYCLES_CIRC - 1);
        endcase
        case (r_state)
            IDLE:    if (w_hs && !w_rsv) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = RUN;
            RUN:     if (r_cnt == '0) w_state_nxt = w_cap ? IDLE : HOLD;
            HOLD:    if (w_cap) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_core_x     <= '0;
            r_core_y     <= '0;
            r_core_z     <= '0;
            r_core_mode  <= 1'b0;
            r_core_coord <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == LOAD) begin
                r_cnt <= w_cnt_load;
            end else if (r_state == RUN && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_hs) begin
                r_core_x     <= i_in_x;
                r_core_y     <= i_in_y;
                r_core_z     <= i_in_z;
                r_core_mode  <= i_in_mode;
                r_core_coord <= i_in_coord;
            end
        end
    end

    // Capture beats the consumer's drain at the same edge, so out_valid stays high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
            r_out_coord <= 2'b00;
            r_out_err   <= 1'b0;
        end else if (w_hs && w_rsv) begin
            r_out_valid <= 1'b1;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_z     <= '0;
            r_out_coord <= 2'b11;
            r_out_err   <= 1'b1;
        end else if (w_cap) begin
            r_out_valid <= 1'b1;
            r_out_x     <= i_core_x;
            r_out_y     <= i_core_y;
            r_out_z     <= i_core_z;
            r_out_coord <= r_core_coord;
            r_out_err   <= 1'b0;
        end else if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_core_x_initial         = r_core_x;
    assign o_core_y_initial         = r_core_y;
    assign o_core_z_initial         = r_core_z;
    assign o_core_mode_bit          = r_core_mode;
    assign o_core_coordinate_system = r_core_coord;
    assign o_core_restart           = (r_state == LOAD);
    assign o_out_valid              = r_out_valid;
    assign o_out_x                  = r_out_x;
    assign o_out_y                  = r_out_y;
    assign o_out_z                  = r_out_z;
    assign o_out_coord              = r_out_coord;
    assign o_out_err                = r_out_err;

endmodule

// File: tb/tb_cordic_job_sequencer.sv
// Scoreboard bench for cordic_job_sequencer; the core is modelled as outputs that change every edge.
`timescale 1ns/1ps
module tb_cordic_job_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_x = '0, in_y = '0, in_z = '0;
    logic       in_mode = 1'b0;
    logic [1:0] in_coord = 2'b00;
    logic [7:0] core_x_initial, core_y_initial, core_z_initial;
    logic       core_mode_bit;
    logic [1:0] core_coordinate_system;
    logic       core_restart;
    logic [7:0] core_x, core_y, core_z;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_x, out_y, out_z;
    logic [1:0] out_coord;
    logic       out_err;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
        logic [1:0] coord;
        logic       err;
    } res_t;

    res_t exp_q[$];
    res_t mon_e, mon_a;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    cordic_job_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_x(in_x), .i_in_y(in_y), .i_in_z(in_z),
        .i_in_mode(in_mode), .i_in_coord(in_coord),
        .o_core_x_initial(core_x_initial), .o_core_y_initial(core_y_initial),
        .o_core_z_initial(core_z_initial), .o_core_mode_bit(core_mode_bit),
        .o_core_coordinate_system(core_coordinate_system), .o_core_restart(core_restart),
        .i_core_x(core_x), .i_core_y(core_y), .i_core_z(core_z),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_x(out_x), .o_out_y(out_y), .o_out_z(out_z),
        .o_out_coord(out_coord), .o_out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gx(input int k); return 8'(k * 7 + 3);  endfunction
    function automatic logic [7:0] gy(input int k); return 8'(k * 5 + 1);  endfunction
    function automatic logic [7:0] gz(input int k); return 8'(k * 11 + 9); endfunction

    // Core model: the value seen at edge k was driven just after edge k-1, i.e. g(k-1).
    initial begin
        core_x = gx(0);
        core_y = gy(0);
        core_z = gz(0);
    end
    always @(posedge clk) begin
        edge_cnt++;
        #1;
        core_x = gx(edge_cnt);
        core_y = gy(edge_cnt);
        core_z = gz(edge_cnt);
    end

    // Result monitor: every output handshake pops and compares the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %h, required no result", {out_x, out_y, out_z, out_coord, out_err});
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = {out_x, out_y, out_z, out_coord, out_err};
                if (mon_a !== mon_e) begin
                    n_fail++;
                    $display("FAIL sb_result: got %h, required %h", mon_a, mon_e);
                end
            end
        end
    end

    // Offer one job; acc is the accepting edge number, or -1 if it was never accepted.
    task automatic send(input logic [7:0] x, y, z, input logic m, input logic [1:0] c, output int acc);
        acc = -1;
        in_x = x; in_y = y; in_z = z; in_mode = m; in_coord = c;
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 60; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk); #1;
                acc = edge_cnt;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int e);
        e = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                e = edge_cnt;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, core_restart, out_err, out_coord} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 00000", {out_valid, core_restart, out_err, out_coord});
        end
        n_checks++;
        if ({core_x_initial, core_y_initial, core_z_initial, core_mode_bit, core_coordinate_system} !== 27'b0) begin
            n_fail++;
            $display("FAIL reset_core: got %h, required 0", {core_x_initial, core_y_initial, core_z_initial});
        end
        n_checks++;
        if ({out_x, out_y, out_z} !== 24'b0) begin
            n_fail++;
            $display("FAIL reset_out: got %h, required 0", {out_x, out_y, out_z});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_circular;
        int acc, e;
        out_ready = 1'b1;
        send(8'h20, 8'h00, 8'h10, 1'b0, 2'b00, acc);
        exp_q.push_back({gx(acc + 12), gy(acc + 12), gz(acc + 12), 2'b00, 1'b0});
        n_checks++;
        if (acc < 0) begin
            n_fail++;
            $display("FAIL circ_accept: got no accept, required accept");
        end
        n_checks++;
        if (core_restart !== 1'b1) begin
            n_fail++;
            $display("FAIL circ_restart_on: got %b, required 1", core_restart);
        end
        n_checks++;
        if ({core_x_initial, core_y_initial, core_z_initial, core_mode_bit} !== {8'h20, 8'h00, 8'h10, 1'b0}) begin
            n_fail++;
            $display("FAIL circ_core_ops: got %h %h %h %b, required 20 00 10 0",
                     core_x_initial, core_y_initial, core_z_initial, core_mode_bit);
        end
        @(posedge clk); #1;
        n_checks++;
        if (core_restart !== 1'b0) begin
            n_fail++;
            $display("FAIL circ_restart_off: got %b, required 0", core_restart);
        end
        wait_valid(e);
        n_checks++;
        if (e - acc !== 13) begin
            n_fail++;
            $display("FAIL circ_latency: got %0d, required 13", e - acc);
        end
        n_checks++;
        if (out_x !== gx(acc + 12) || out_coord !== 2'b00) begin
            n_fail++;
            $display("FAIL circ_out: got x=%h coord=%b, required x=%h coord=00", out_x, out_coord, gx(acc + 12));
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] coords [2];
        int         lat    [2];
        int         acc, e;
        logic       bad;
        coords[0] = 2'b01; lat[0] = 10;
        coords[1] = 2'b10; lat[1] = 14;
        out_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            send(8'(8'h30 + j), 8'(8'h40 + j), 8'(8'h50 + j), 1'b1, coords[j], acc);
            exp_q.push_back({gx(acc + lat[j]), gy(acc + lat[j]), gz(acc + lat[j]), coords[j], 1'b0});
            bad = (in_ready !== 1'b0);
            e = -1;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (out_valid === 1'b1) begin
                    e = edge_cnt;
                    break;
                end
                if (in_ready !== 1'b0) bad = 1'b1;
            end
            n_checks++;
            if (bad !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_in_ready_low job%0d: got in_ready high during job, required low", j);
            end
            n_checks++;
            if (e - acc !== lat[j] + 1) begin
                n_fail++;
                $display("FAIL b2b_latency job%0d: got %0d, required %0d", j, e - acc, lat[j] + 1);
            end
        end
    endtask

    task automatic test_hold;
        int acc1, acc2, e1, t;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h11, 8'h22, 8'h33, 1'b0, 2'b00, acc1);
        exp_q.push_back({gx(acc1 + 12), gy(acc1 + 12), gz(acc1 + 12), 2'b00, 1'b0});
        wait_valid(e1);
        n_checks++;
        if (e1 - acc1 !== 13) begin
            n_fail++;
            $display("FAIL hold_job1_latency: got %0d, required 13", e1 - acc1);
        end
        send(8'h44, 8'h55, 8'h66, 1'b1, 2'b01, acc2);
        repeat (acc2 + 12 - edge_cnt) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_valid !== 1'b1 || out_x !== gx(acc1 + 12) || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_parked: got valid=%b x=%h in_ready=%b, required 1 %h 0",
                     out_valid, out_x, in_ready, gx(acc1 + 12));
        end
        t = edge_cnt;
        exp_q.push_back({gx(t), gy(t), gz(t), 2'b01, 1'b0});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got valid=%b in_ready=%b, required 1 1", out_valid, in_ready);
        end
        n_checks++;
        if (out_x !== gx(t) || out_coord !== 2'b01) begin
            n_fail++;
            $display("FAIL hold_capture: got x=%h coord=%b, required x=%h coord=01", out_x, out_coord, gx(t));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_drain: got valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_reserved;
        int   acc;
        logic seen;
        out_ready = 1'b1;
        send(8'h55, 8'h66, 8'h77, 1'b1, 2'b11, acc);
        exp_q.push_back({8'h00, 8'h00, 8'h00, 2'b11, 1'b1});
        n_checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_coord !== 2'b11) begin
            n_fail++;
            $display("FAIL rsv_flags: got valid=%b err=%b coord=%b, required 1 1 11", out_valid, out_err, out_coord);
        end
        n_checks++;
        if ({out_x, out_y, out_z} !== 24'b0) begin
            n_fail++;
            $display("FAIL rsv_data: got %h, required 0", {out_x, out_y, out_z});
        end
        n_checks++;
        if (in_ready !== 1'b1 || core_coordinate_system !== 2'b11 || core_mode_bit !== 1'b1) begin
            n_fail++;
            $display("FAIL rsv_state: got in_ready=%b coord=%b mode=%b, required 1 11 1",
                     in_ready, core_coordinate_system, core_mode_bit);
        end
        seen = core_restart;
        repeat (5) begin
            @(posedge clk); #1;
            if (core_restart !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_no_restart: got core_restart pulse, required none");
        end
    endtask

    task automatic test_reset_mid_run;
        int acc;
        out_ready = 1'b0;
        send(8'h01, 8'h02, 8'h03, 1'b0, 2'b11, acc);
        exp_q.push_back({8'h00, 8'h00, 8'h00, 2'b11, 1'b1});
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_blocked: got in_ready=%b with full output, required 0", in_ready);
        end
        send(8'h7a, 8'h7b, 8'h7c, 1'b1, 2'b00, acc);
        repeat (acc + 7 - edge_cnt) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        n_checks++;
        if (out_valid !== 1'b0 || core_restart !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_ctrl: got valid=%b restart=%b, required 0 0", out_valid, core_restart);
        end
        n_checks++;
        if ({core_x_initial, core_y_initial, core_z_initial, core_mode_bit, core_coordinate_system} !== 27'b0) begin
            n_fail++;
            $display("FAIL arst_core: got %h, required 0", {core_x_initial, core_y_initial, core_z_initial});
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_release: got in_ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset;
        test_circular;
        test_back_to_back;
        test_hold;
        test_reserved;
        test_reset_mid_run;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending results, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
